// File: rtl/tree_pkg.sv
// Shared definitions for the selection tree and its drain stage.
package tree_pkg;

  localparam int LEN_DEF   = 16;
  localparam int NUM_DEF   = 4096;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [LEN_DEF-2:0] payload;
    logic               hit;
  } entry_t;

  function automatic int tree_lat(input int num);
    return $clog2(num);
  endfunction

endpackage

// File: rtl/tree_result_fifo.sv
// Result FIFO with a registered head entry; clear empties it in one cycle.
module tree_result_fifo
  import tree_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Head tracks the entry that will be at rd_ptr after this edge; holds when emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (!clear) begin
      if (do_pop) begin
        if (count > CW'(1)) head <= mem[rd_nxt];
        else if (do_push)   head <= push_data;
      end else if (empty && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/tree_drain.sv
// Drain stage behind the pipelined selection tree: latency-matched tag line,
// result capture into a FIFO, launch credits and hit/miss statistics.
module tree_drain
  import tree_pkg::*;
#(
  parameter int NUM   = NUM_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int LAT   = tree_lat(NUM),
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             launch,
  output logic             launch_ready,
  input  logic [LEN-1:0]   sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-2:0]   out_data,
  output logic             out_hit,
  output logic             overflow,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef logic [LAT-1:0] tag_t;

  tag_t          tag;
  logic          capture;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   credit_used;
  entry_t        cap_entry;
  entry_t        head;

  assign capture           = tag[LAT-1];
  assign pop               = ~empty & out_ready;
  assign cap_entry.payload = sum[LEN-1:1];
  assign cap_entry.hit     = sum[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tag <= '0;
    else if (clear) tag <= '0;
    else            tag <= tag_t'({tag, launch});
  end

  tree_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (capture),
    .push_data (cap_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Credits count results already buffered plus those still inside the tree.
  assign credit_used  = 32'(fifo_count) + 32'($countones(tag));
  assign launch_ready = (credit_used < 32'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (capture) begin
      if (full && !pop) overflow <= 1'b1;
      if (sum[0]) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = ~empty;
  assign out_data  = head.payload;
  assign out_hit   = head.hit;

endmodule

// File: tb/tb_tree_drain.sv
// Directed bench for tree_drain with an 8-input tree (three-cycle latency).
module tb_tree_drain;

  localparam int NUM   = 8;
  localparam int LEN   = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             launch;
  logic             launch_ready;
  logic [LEN-1:0]   sum;
  logic             out_valid;
  logic             out_ready;
  logic [LEN-2:0]   out_data;
  logic             out_hit;
  logic             overflow;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tree_drain #(
    .NUM   (NUM),
    .LEN   (LEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .launch       (launch),
    .launch_ready (launch_ready),
    .sum          (sum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_hit      (out_hit),
    .overflow     (overflow),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [LEN-1:0] vals  [4];
    logic [LEN-1:0] drain [4];
    vals  = '{16'h1235, 16'h2468, 16'hFFFF, 16'h0002};
    drain = '{16'h2468, 16'hFFFF, 16'h0002, 16'h5555};

    rst_n = 1'b0; clear = 1'b0; launch = 1'b0; out_ready = 1'b0; sum = '0;
    #3;
    chk("rst_out_valid",    64'(out_valid),    64'(0));
    chk("rst_out_data",     64'(out_data),     64'(0));
    chk("rst_out_hit",      64'(out_hit),      64'(0));
    chk("rst_overflow",     64'(overflow),     64'(0));
    chk("rst_hit_cnt",      64'(hit_cnt),      64'(0));
    chk("rst_miss_cnt",     64'(miss_cnt),     64'(0));
    chk("rst_launch_ready", 64'(launch_ready), 64'(1));
    step(); step();
    rst_n = 1'b1;
    step();

    // single launch: captured at the third edge after launch, visible one edge later
    launch = 1'b1; step(); launch = 1'b0;
    step(); step();
    chk("single_pre_valid", 64'(out_valid), 64'(0));
    sum = 16'h00A5; step(); sum = '0;
    chk("single_valid",    64'(out_valid), 64'(1));
    chk("single_data",     64'(out_data),  64'(15'h0052));
    chk("single_hit",      64'(out_hit),   64'(1));
    chk("single_hit_cnt",  64'(hit_cnt),   64'(1));
    chk("single_miss_cnt", 64'(miss_cnt),  64'(0));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("single_popped",   64'(out_valid),    64'(0));
    chk("single_ready",    64'(launch_ready), 64'(1));

    // stalled consumer: four back-to-back launches fill the FIFO
    for (int k = 0; k < 7; k++) begin
      launch = (k < 4);
      if (k >= 3) sum = vals[k-3];
      else        sum = '0;
      step();
      if (k == 2) chk("stall_ready_3used", 64'(launch_ready), 64'(1));
      if (k == 3) chk("stall_ready_4used", 64'(launch_ready), 64'(0));
    end
    launch = 1'b0; sum = '0;
    chk("stall_ready_full", 64'(launch_ready), 64'(0));
    chk("stall_overflow",   64'(overflow),     64'(0));
    chk("stall_valid",      64'(out_valid),    64'(1));
    chk("stall_head_data",  64'(out_data),     64'(vals[0][15:1]));
    chk("stall_head_hit",   64'(out_hit),      64'(vals[0][0]));
    chk("stall_hit_cnt",    64'(hit_cnt),      64'(3));
    chk("stall_miss_cnt",   64'(miss_cnt),     64'(2));

    // full FIFO, capture coincides with a pop: no drop
    launch = 1'b1; step(); launch = 1'b0;
    step(); step();
    sum = 16'h5555; out_ready = 1'b1; step(); out_ready = 1'b0; sum = '0;
    chk("fullpop_overflow",  64'(overflow),     64'(0));
    chk("fullpop_ready",     64'(launch_ready), 64'(0));
    chk("fullpop_head_data", 64'(out_data),     64'(15'h1234));
    chk("fullpop_head_hit",  64'(out_hit),      64'(0));
    chk("fullpop_hit_cnt",   64'(hit_cnt),      64'(4));

    // forced drop: launch without credit while full and stalled
    launch = 1'b1; step(); launch = 1'b0;
    step(); step();
    sum = 16'h0100; step(); sum = '0;
    chk("drop_overflow",  64'(overflow), 64'(1));
    chk("drop_miss_cnt",  64'(miss_cnt), 64'(3));
    chk("drop_hit_cnt",   64'(hit_cnt),  64'(4));
    chk("drop_head_data", 64'(out_data), 64'(15'h1234));
    chk("drop_head_hit",  64'(out_hit),  64'(0));

    // drain in order; the entry captured during the full pop comes last
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("drain%0d_data", i),  64'(out_data),  64'(drain[i][15:1]));
      chk($sformatf("drain%0d_hit", i),   64'(out_hit),   64'(drain[i][0]));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(out_valid),    64'(0));
    chk("drain_ready", 64'(launch_ready), 64'(1));

    // clear with two results buffered and two tags in flight
    for (int k = 0; k < 5; k++) begin
      launch = (k < 4);
      if (k == 3)      sum = 16'h0011;
      else if (k == 4) sum = 16'h0020;
      else             sum = '0;
      step();
    end
    launch = 1'b0;
    chk("preclr_valid", 64'(out_valid),    64'(1));
    chk("preclr_ready", 64'(launch_ready), 64'(0));
    clear = 1'b1; launch = 1'b1; sum = 16'h0003; step();
    clear = 1'b0; launch = 1'b0;
    chk("clr_valid",    64'(out_valid),    64'(0));
    chk("clr_hit_cnt",  64'(hit_cnt),      64'(0));
    chk("clr_miss_cnt", 64'(miss_cnt),     64'(0));
    chk("clr_overflow", 64'(overflow),     64'(0));
    chk("clr_ready",    64'(launch_ready), 64'(1));
    sum = 16'h0007;
    repeat (4) step();
    sum = '0;
    chk("postclr_valid",    64'(out_valid), 64'(0));
    chk("postclr_hit_cnt",  64'(hit_cnt),   64'(0));
    chk("postclr_miss_cnt", 64'(miss_cnt),  64'(0));

    // asynchronous reset mid-cycle with a result buffered and a tag in flight
    launch = 1'b1; step(); launch = 1'b0;
    step(); step();
    sum = 16'h00A5; launch = 1'b1; step(); launch = 1'b0; sum = '0;
    chk("prerst_valid",   64'(out_valid), 64'(1));
    chk("prerst_hit_cnt", 64'(hit_cnt),   64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    64'(out_valid),    64'(0));
    chk("arst_data",     64'(out_data),     64'(0));
    chk("arst_hit",      64'(out_hit),      64'(0));
    chk("arst_overflow", 64'(overflow),     64'(0));
    chk("arst_hit_cnt",  64'(hit_cnt),      64'(0));
    chk("arst_miss_cnt", 64'(miss_cnt),     64'(0));
    chk("arst_ready",    64'(launch_ready), 64'(1));
    step();
    rst_n = 1'b1;
    sum = 16'h0009;
    repeat (4) step();
    sum = '0;
    chk("postrst_valid",   64'(out_valid), 64'(0));
    chk("postrst_hit_cnt", 64'(hit_cnt),   64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
